// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity codes and baud divisor helper for the UART blocks
// Contents:
//   rx_state_t  receiver state encoding
//   PAR_*       parity mode codes
//   calc_div    clock cycles per oversample tick, rounded to nearest
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int calc_div(input int clock_freq, input int baud_rate, input int oversample);
      return (clock_freq + baud_rate * oversample / 2) / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   tick     out  one-cycle pulse every DIV clocks
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with majority vote, break detect and output FIFO
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous
//   rx_data    out  head-of-FIFO data
//   rx_perr    out  head entry parity error
//   rx_ferr    out  head entry framing error
//   rx_valid   out  FIFO not empty
//   rx_ready   in   consumer accepts head entry
//   overrun    out  pulse: completed frame dropped, FIFO full
//   break_det  out  pulse: line break detected
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DBIT       = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_perr,
   output logic            rx_ferr,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            overrun,
   output logic            break_det
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DBIT);
   localparam int FW = DBIT + 2;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [SW-1:0] S_SMP0   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_SMP1   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   logic            rx_meta, rxs;
   logic            tick;
   rx_state_t       state;
   logic [SW-1:0]   s;
   logic [NW-1:0]   n;
   logic            smp0, smp1;
   logic [DBIT-1:0] shreg;
   logic            par_bit, ferr_acc, stop_one, stop_idx;
   logic            done, done_brk;
   logic [FW-1:0]   done_word;
   logic            bit_val, last_stop, ferr_fin, perr_fin, brk_fin;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   uart_baud_tick #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // Third sample is the live rxs at the decision tick.
   assign bit_val   = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
   assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
   assign ferr_fin  = ferr_acc | ~bit_val;
   // Break: every decided bit of the frame was 0, including all stop bits.
   assign brk_fin   = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !stop_one && !bit_val;

   always_comb begin
      perr_fin = 1'b0;
      if (PARITY == PAR_EVEN)
         perr_fin = ^{shreg, par_bit};
      else if (PARITY == PAR_ODD)
         perr_fin = ~^{shreg, par_bit};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         s         <= '0;
         n         <= '0;
         smp0      <= 1'b1;
         smp1      <= 1'b1;
         shreg     <= '0;
         par_bit   <= 1'b0;
         ferr_acc  <= 1'b0;
         stop_one  <= 1'b0;
         stop_idx  <= 1'b0;
         done      <= 1'b0;
         done_brk  <= 1'b0;
         done_word <= '0;
      end else begin
         done     <= 1'b0;
         done_brk <= 1'b0;
         if (tick && (s == S_SMP0)) smp0 <= rxs;
         if (tick && (s == S_SMP1)) smp1 <= rxs;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if ((s == S_DEC) && bit_val) begin
                     state <= IDLE;
                  end else if (s == S_LAST) begin
                     state <= DATA;
                     s     <= '0;
                     n     <= '0;
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  // LSB arrives first, so shifting in from the top leaves it at bit 0.
                  if (s == S_DEC) shreg <= {bit_val, shreg[DBIT-1:1]};
                  if (s == S_LAST) begin
                     s <= '0;
                     if (n == N_LAST) begin
                        state    <= (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                        stop_idx <= 1'b0;
                        ferr_acc <= 1'b0;
                        stop_one <= 1'b0;
                     end else begin
                        n <= n + NW'(1);
                     end
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (tick) begin
                  if (s == S_DEC) par_bit <= bit_val;
                  if (s == S_LAST) begin
                     s     <= '0;
                     state <= STOP;
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (s == S_DEC) begin
                     ferr_acc <= ferr_fin;
                     stop_one <= stop_one | bit_val;
                     // Finish mid-stop-bit so a back-to-back start edge is not missed.
                     if (last_stop) begin
                        done      <= 1'b1;
                        done_brk  <= brk_fin;
                        done_word <= {ferr_fin, perr_fin, shreg};
                        state     <= brk_fin ? BRK : IDLE;
                     end
                  end
                  if (s == S_LAST) begin
                     s        <= '0;
                     stop_idx <= stop_idx + 1'b1;
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            BRK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          pop, push, full;

   assign rx_valid = (count != '0);
   assign full     = (count == CNT_FULL);
   assign pop      = rx_valid && rx_ready;
   assign push     = done && !done_brk && (!full || pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         break_det <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         overrun   <= done && !done_brk && full && !pop;
         break_det <= done && done_brk;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= done_word;
   end

   // Outputs read as zero while empty so reset and drained states look identical.
   assign {rx_ferr, rx_perr, rx_data} = rx_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (8N1, 8E1, 8O1 at DIV=4, OS=16)
module tb_uart_rx_param;

   localparam int CF       = 7_372_800;
   localparam int BR       = 115200;
   localparam int OS       = 16;
   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_n, rx_p;
   logic       ready_n, ready_p;
   logic [7:0] data_n, data_e, data_o;
   logic       perr_n, perr_e, perr_o;
   logic       ferr_n, ferr_e, ferr_o;
   logic       valid_n, valid_e, valid_o;
   logic       ovr_n, ovr_e, ovr_o;
   logic       brk_n, brk_e, brk_o;

   int checks   = 0;
   int failures = 0;
   int ovr_cnt  = 0;
   int brk_cnt  = 0;

   always #5 clk = ~clk;

   uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DBIT(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx_n), .rx_data(data_n), .rx_perr(perr_n),
      .rx_ferr(ferr_n), .rx_valid(valid_n), .rx_ready(ready_n), .overrun(ovr_n), .break_det(brk_n));

   uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DBIT(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
      .clk(clk), .reset_n(reset_n), .rx(rx_p), .rx_data(data_e), .rx_perr(perr_e),
      .rx_ferr(ferr_e), .rx_valid(valid_e), .rx_ready(ready_p), .overrun(ovr_e), .break_det(brk_e));

   uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DBIT(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
      .clk(clk), .reset_n(reset_n), .rx(rx_p), .rx_data(data_o), .rx_perr(perr_o),
      .rx_ferr(ferr_o), .rx_valid(valid_o), .rx_ready(ready_p), .overrun(ovr_o), .break_det(brk_o));

   always @(posedge clk) begin
      if (ovr_n) ovr_cnt++;
      if (brk_n) brk_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic valid_of(input int w);
      case (w)
         0:       return valid_n;
         1:       return valid_e;
         default: return valid_o;
      endcase
   endfunction

   function automatic logic [9:0] head_of(input int w);
      case (w)
         0:       return {ferr_n, perr_n, data_n};
         1:       return {ferr_e, perr_e, data_e};
         default: return {ferr_o, perr_o, data_o};
      endcase
   endfunction

   task automatic set_line(input int which, input logic v);
      if (which == 0) rx_n = v;
      else            rx_p = v;
   endtask

   // bits[0] goes first on the line; glitch_bit inverts clocks 32..35 of that bit.
   task automatic send_bits(input int which, input logic [15:0] bits, input int nbits, input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < BIT_CLKS; c++) begin
            if (i == glitch_bit && c >= 32 && c < 36) set_line(which, ~bits[i]);
            else                                      set_line(which, bits[i]);
            @(negedge clk);
         end
      end
      set_line(which, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_bits(0, {6'h3f, 1'b1, d, 1'b0}, 10, -1);
   endtask

   task automatic send_par(input logic [7:0] d, input logic p);
      send_bits(1, {5'h1f, 1'b1, p, d, 1'b0}, 11, -1);
   endtask

   task automatic idle_bits(input int nb);
      repeat (nb * BIT_CLKS) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag, input int w);
      int k;
      k = 0;
      while (!valid_of(w) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check({tag, " valid"}, 32'(valid_of(w)), 32'd1);
   endtask

   task automatic pop_expect(input string tag, input logic [9:0] exp);
      wait_valid(tag, 0);
      check({tag, " head"}, 32'(head_of(0)), 32'(exp));
      ready_n = 1'b1;
      @(negedge clk);
      ready_n = 1'b0;
   endtask

   initial begin
      int o0, b0;
      logic [9:0] f;
      reset_n = 1'b0;
      rx_n    = 1'b1;
      rx_p    = 1'b1;
      ready_n = 1'b0;
      ready_p = 1'b0;
      repeat (5) @(negedge clk);
      check("rst valid", 32'(valid_n), 32'd0);
      check("rst data", 32'(data_n), 32'd0);
      check("rst perr", 32'(perr_n), 32'd0);
      check("rst ferr", 32'(ferr_n), 32'd0);
      check("rst overrun", 32'(ovr_n), 32'd0);
      check("rst break", 32'(brk_n), 32'd0);
      reset_n = 1'b1;
      idle_bits(2);

      // 8N1 0xA5, held until ready
      send_byte(8'hA5);
      wait_valid("a5", 0);
      check("a5 head", 32'(head_of(0)), 32'h0A5);
      repeat (200) @(negedge clk);
      check("a5 hold valid", 32'(valid_n), 32'd1);
      check("a5 hold head", 32'(head_of(0)), 32'h0A5);
      ready_n = 1'b1;
      @(negedge clk);
      ready_n = 1'b0;
      check("a5 popped", 32'(valid_n), 32'd0);

      // parity: 0x07 has three ones
      send_par(8'h07, 1'b0);
      wait_valid("par0 e", 1);
      check("par0 even", 32'(head_of(1)), 32'h107);
      check("par0 odd", 32'(head_of(2)), 32'h007);
      ready_p = 1'b1;
      @(negedge clk);
      ready_p = 1'b0;
      send_par(8'h07, 1'b1);
      wait_valid("par1 e", 1);
      check("par1 even", 32'(head_of(1)), 32'h007);
      check("par1 odd", 32'(head_of(2)), 32'h107);
      ready_p = 1'b1;
      @(negedge clk);
      ready_p = 1'b0;
      check("par drained", 32'(valid_e), 32'd0);

      // false start: 4 ticks low
      rx_n = 1'b0;
      repeat (16) @(negedge clk);
      rx_n = 1'b1;
      idle_bits(3);
      check("false start", 32'(valid_n), 32'd0);

      // one-tick high glitch in data bit 1 (a 0) of 0x81
      send_bits(0, {6'h3f, 1'b1, 8'h81, 1'b0}, 10, 2);
      pop_expect("glitch", 10'h081);

      // overrun on the fifth byte
      o0 = ovr_cnt;
      for (int d = 1; d <= 5; d++) send_byte(8'(d));
      idle_bits(1);
      check("overrun count", 32'(ovr_cnt - o0), 32'd1);
      for (int d = 1; d <= 4; d++) pop_expect("ovr drain", 10'(d));
      check("ovr empty", 32'(valid_n), 32'd0);

      // break: two frame times low
      b0 = brk_cnt;
      rx_n = 1'b0;
      repeat (20 * BIT_CLKS) @(negedge clk);
      rx_n = 1'b1;
      idle_bits(2);
      check("break count", 32'(brk_cnt - b0), 32'd1);
      check("break no entry", 32'(valid_n), 32'd0);
      send_byte(8'h55);
      pop_expect("after break", 10'h055);

      // reset mid data bit 4, with an entry pending in the FIFO
      send_byte(8'h99);
      wait_valid("pending", 0);
      f = {1'b1, 8'h3C, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx_n = f[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx_n = f[5];
      repeat (32) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid rst valid", 32'(valid_n), 32'd0);
      check("mid rst head", 32'(head_of(0)), 32'd0);
      check("mid rst pulses", 32'({ovr_n, brk_n}), 32'd0);
      rx_n = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      idle_bits(2);
      check("post rst empty", 32'(valid_n), 32'd0);
      send_byte(8'h3C);
      pop_expect("post rst", 10'h03C);
      check("final empty", 32'(valid_n), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
